// File: rtl/openmips_pkg.sv
// openmips_pkg: memory op encoding, byte-enable constants, word type and alignment helper shared by the MEM stage
package openmips_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    MEM_NONE, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
  } mem_op_e;
  localparam logic [3:0] BE_B  = 4'b1000;
  localparam logic [3:0] BE_HH = 4'b1100;
  localparam logic [3:0] BE_HL = 4'b0011;
  localparam logic [3:0] BE_W  = 4'b1111;
  function automatic logic misaligned(input mem_op_e op, input logic [1:0] off);
    return (op inside {MEM_LH, MEM_LHU, MEM_SH}) ? off[0] :
           (op inside {MEM_LW, MEM_SW}) ? (off != 2'b00) : 1'b0;
  endfunction
endpackage

// File: rtl/dr_reg.sv
// dr_reg: W-bit register with synchronous active-low clear (clk, rst_, d -> q)
module dr_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= !rst_ ? '0 : d;
endmodule

// File: rtl/mem_access_align.sv
// mem_align: big-endian store lane steering (op, off, sdata -> be, wdata) and load extraction (rdata -> ldata)
module mem_align
  import openmips_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  off,
  input  word_t       sdata,
  input  word_t       rdata,
  output logic [3:0]  be,
  output word_t       wdata,
  output word_t       ldata
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  always_comb begin
    byte_v = off == 2'd0 ? rdata[31:24] : off == 2'd1 ? rdata[23:16] :
             off == 2'd2 ? rdata[15:8]  : rdata[7:0];
    half_v = off[1] ? rdata[15:0] : rdata[31:16];
    be = (op inside {MEM_LB, MEM_LBU, MEM_SB}) ? BE_B >> off :
         (op inside {MEM_LH, MEM_LHU, MEM_SH}) ? (off[1] ? BE_HL : BE_HH) :
         (op inside {MEM_LW, MEM_SW}) ? BE_W : 4'b0000;
    wdata = op == MEM_SB ? {4{sdata[7:0]}} : op == MEM_SH ? {2{sdata[15:0]}} : sdata;
    ldata = op == MEM_LB  ? {{24{byte_v[7]}}, byte_v} :
            op == MEM_LBU ? {24'd0, byte_v} :
            op == MEM_LH  ? {{16{half_v[15]}}, half_v} :
            op == MEM_LHU ? {16'd0, half_v} : rdata;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: openMIPS MEM stage; ex_o_* in, mem_o_* to mem_wb, stallreq upstream, req/ack dbus with misalign/timeout pulses
module mem_access
  import openmips_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic [4:0]  ex_o_waddr,
  input  logic        ex_o_wreg,
  input  word_t       ex_o_wdata,
  input  logic        ex_o_we_hilo,
  input  word_t       ex_o_wdata_hi,
  input  word_t       ex_o_wdata_lo,
  input  mem_op_e     ex_o_mem_op,
  input  word_t       ex_o_mem_addr,
  input  word_t       ex_o_mem_sdata,
  output logic [4:0]  mem_o_waddr,
  output logic        mem_o_wreg,
  output word_t       mem_o_wdata,
  output logic        mem_o_we_hilo,
  output word_t       mem_o_wdata_hi,
  output word_t       mem_o_wdata_lo,
  output logic        mem_o_misalign,
  output logic        mem_o_buserr,
  output logic        stallreq,
  output logic        dbus_req,
  output logic        dbus_we,
  output word_t       dbus_addr,
  output logic [3:0]  dbus_be,
  output word_t       dbus_wdata,
  input  logic        dbus_ack,
  input  word_t       dbus_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef struct packed {
    state_e      st;
    logic        req;
    logic        we;
    word_t       addr;
    logic [3:0]  be;
    word_t       wdata;
    word_t       rdata;
    logic        err;
    logic [31:0] timer;
  } regs_t;
  regs_t      r_d, r_q;
  logic [3:0] be;
  word_t      wdata, ldata;
  logic       is_store, is_load;
  dr_reg #(.W($bits(regs_t))) u_regs (.clk(clk), .rst_(rst_), .d(r_d), .q(r_q));
  mem_align u_align (
    .op(ex_o_mem_op), .off(ex_o_mem_addr[1:0]), .sdata(ex_o_mem_sdata),
    .rdata(r_q.rdata), .be(be), .wdata(wdata), .ldata(ldata)
  );
  assign dbus_req   = r_q.req;
  assign dbus_we    = r_q.we;
  assign dbus_addr  = r_q.addr;
  assign dbus_be    = r_q.be;
  assign dbus_wdata = r_q.wdata;
  always_comb begin
    r_d            = r_q;
    is_store       = ex_o_mem_op inside {MEM_SB, MEM_SH, MEM_SW};
    is_load        = ex_o_mem_op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    mem_o_waddr    = ex_o_waddr;
    mem_o_wreg     = ex_o_wreg;
    mem_o_wdata    = ex_o_wdata;
    mem_o_we_hilo  = ex_o_we_hilo;
    mem_o_wdata_hi = ex_o_wdata_hi;
    mem_o_wdata_lo = ex_o_wdata_lo;
    mem_o_misalign = 1'b0;
    mem_o_buserr   = 1'b0;
    stallreq       = 1'b0;
    case (r_q.st)
      IDLE: if (ex_o_mem_op != MEM_NONE) begin
        mem_o_wreg    = 1'b0;
        mem_o_we_hilo = 1'b0;
        if (misaligned(ex_o_mem_op, ex_o_mem_addr[1:0])) mem_o_misalign = 1'b1;
        else begin
          stallreq  = 1'b1;
          r_d.st    = BUSY;
          r_d.req   = 1'b1;
          r_d.we    = is_store;
          r_d.addr  = {ex_o_mem_addr[31:2], 2'b00};
          r_d.be    = be;
          r_d.wdata = is_store ? wdata : '0;
          r_d.err   = 1'b0;
          r_d.timer = '0;
        end
      end
      BUSY: begin
        stallreq      = 1'b1;
        mem_o_wreg    = 1'b0;
        mem_o_we_hilo = 1'b0;
        r_d.timer     = r_q.timer + 32'd1;
        if (dbus_ack) begin
          r_d.rdata = dbus_rdata;
          r_d.req   = 1'b0;
          r_d.st    = DONE;
        end else if (BUS_TIMEOUT != 0 && r_q.timer == BUS_TIMEOUT - 1) begin
          r_d.req = 1'b0;
          r_d.err = 1'b1;
          r_d.st  = DONE;
        end
      end
      DONE: begin
        r_d.st = IDLE;
        if (r_q.err) begin
          mem_o_wreg   = 1'b0;
          mem_o_buserr = 1'b1;
        end else if (is_load) mem_o_wdata = ldata;
      end
      default: r_d.st = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized self-checking bench for mem_access against a lane-arithmetic reference model
module tb_mem_access;
  import openmips_pkg::*;
  localparam int TO = 4;
  logic       clk = 1'b0, rst_;
  logic [4:0] ex_o_waddr, mem_o_waddr;
  logic       ex_o_wreg, ex_o_we_hilo, mem_o_wreg, mem_o_we_hilo;
  word_t      ex_o_wdata, ex_o_wdata_hi, ex_o_wdata_lo, ex_o_mem_addr, ex_o_mem_sdata;
  word_t      mem_o_wdata, mem_o_wdata_hi, mem_o_wdata_lo;
  mem_op_e    ex_o_mem_op;
  logic       mem_o_misalign, mem_o_buserr, stallreq, dbus_req, dbus_we, dbus_ack;
  word_t      dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0] dbus_be;
  int nvec = 0, nerr = 0;
  mem_op_e all_ops [8] = '{MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW};

  always #5 clk = ~clk;

  mem_access #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst_(rst_),
    .ex_o_waddr(ex_o_waddr), .ex_o_wreg(ex_o_wreg), .ex_o_wdata(ex_o_wdata),
    .ex_o_we_hilo(ex_o_we_hilo), .ex_o_wdata_hi(ex_o_wdata_hi), .ex_o_wdata_lo(ex_o_wdata_lo),
    .ex_o_mem_op(ex_o_mem_op), .ex_o_mem_addr(ex_o_mem_addr), .ex_o_mem_sdata(ex_o_mem_sdata),
    .mem_o_waddr(mem_o_waddr), .mem_o_wreg(mem_o_wreg), .mem_o_wdata(mem_o_wdata),
    .mem_o_we_hilo(mem_o_we_hilo), .mem_o_wdata_hi(mem_o_wdata_hi), .mem_o_wdata_lo(mem_o_wdata_lo),
    .mem_o_misalign(mem_o_misalign), .mem_o_buserr(mem_o_buserr), .stallreq(stallreq),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic rand_ex;
    ex_o_waddr     = 5'($urandom);
    ex_o_wreg      = 1'($urandom);
    ex_o_wdata     = $urandom;
    ex_o_we_hilo   = 1'($urandom);
    ex_o_wdata_hi  = $urandom;
    ex_o_wdata_lo  = $urandom;
    ex_o_mem_sdata = $urandom;
  endtask

  function automatic void model(input mem_op_e op, input word_t addr, input word_t sdata,
                                input word_t rdata, output logic [3:0] be, output word_t wd,
                                output word_t ld);
    int unsigned off, b, h;
    off = int'(addr[1:0]);
    b   = (rdata / (32'd1 << (8 * (3 - off)))) % 256;
    h   = off == 0 ? rdata / 65536 : rdata % 65536;
    be  = 4'b0000;
    wd  = 32'd0;
    ld  = 32'd0;
    case (op)
      MEM_LB:  begin be = 4'(1 << (3 - off)); ld = b >= 128 ? b + 32'hFFFFFF00 : b; end
      MEM_LBU: begin be = 4'(1 << (3 - off)); ld = b; end
      MEM_LH:  begin be = off == 0 ? 4'b1100 : 4'b0011; ld = h >= 32768 ? h + 32'hFFFF0000 : h; end
      MEM_LHU: begin be = off == 0 ? 4'b1100 : 4'b0011; ld = h; end
      MEM_LW:  begin be = 4'b1111; ld = rdata; end
      MEM_SB:  begin be = 4'(1 << (3 - off)); wd = (sdata % 256) * 32'h01010101; end
      MEM_SH:  begin be = off == 0 ? 4'b1100 : 4'b0011; wd = (sdata % 65536) * 32'h00010001; end
      MEM_SW:  begin be = 4'b1111; wd = sdata; end
      default: ;
    endcase
  endfunction

  task automatic mem_txn(input mem_op_e op, input word_t addr, input word_t rdata, input int dly);
    logic [3:0] ebe;
    word_t      ewd, eld, ewdata;
    logic       ewreg, store;
    int         stalls;
    rand_ex();
    ex_o_mem_op   = op;
    ex_o_mem_addr = addr;
    dbus_ack      = 1'b0;
    store  = op inside {MEM_SB, MEM_SH, MEM_SW};
    ewreg  = ex_o_wreg;
    ewdata = ex_o_wdata;
    model(op, addr, ex_o_mem_sdata, rdata, ebe, ewd, eld);
    #1;
    stalls = int'(stallreq);
    nvec++;
    if (stallreq !== 1'b1 || mem_o_wreg !== 1'b0 || mem_o_we_hilo !== 1'b0 || dbus_req !== 1'b0) begin
      nerr++;
      $display("FAIL issue %s @%h: stall=%b wreg=%b hilo=%b req=%b, want 1 0 0 0",
               op.name(), addr, stallreq, mem_o_wreg, mem_o_we_hilo, dbus_req);
    end
    tick();
    nvec++;
    if (dbus_req !== 1'b1 || dbus_we !== store || dbus_addr !== addr - (addr % 4) ||
        dbus_be !== ebe || (store && dbus_wdata !== ewd)) begin
      nerr++;
      $display("FAIL bus %s @%h: req=%b we=%b addr=%h be=%b wdata=%h, want 1 %b %h %b %h",
               op.name(), addr, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
               store, addr - (addr % 4), ebe, ewd);
    end
    for (int i = 0; i <= dly; i++) begin
      if (i == dly) begin
        dbus_ack   = 1'b1;
        dbus_rdata = rdata;
      end
      #1;
      stalls += int'(stallreq);
      nvec++;
      if (mem_o_wreg !== 1'b0 || mem_o_we_hilo !== 1'b0 || dbus_req !== 1'b1) begin
        nerr++;
        $display("FAIL busy %s: wreg=%b hilo=%b req=%b, want 0 0 1", op.name(),
                 mem_o_wreg, mem_o_we_hilo, dbus_req);
      end
      tick();
    end
    dbus_ack   = 1'b0;
    dbus_rdata = $urandom;
    #1;
    stalls += int'(stallreq);
    nvec++;
    if (stalls != dly + 2 || mem_o_wreg !== ewreg || mem_o_wdata !== (store ? ewdata : eld) ||
        mem_o_buserr !== 1'b0 || dbus_req !== 1'b0) begin
      nerr++;
      $display("FAIL done %s @%h: stalls=%0d wreg=%b wdata=%h buserr=%b req=%b, want %0d %b %h 0 0",
               op.name(), addr, stalls, mem_o_wreg, mem_o_wdata, mem_o_buserr, dbus_req,
               dly + 2, ewreg, store ? ewdata : eld);
    end
    tick();
    ex_o_mem_op = MEM_NONE;
    #1;
  endtask

  task automatic test_reset;
    rst_ = 1'b0;
    rand_ex();
    ex_o_mem_op   = MEM_NONE;
    ex_o_mem_addr = '0;
    dbus_ack      = 1'b0;
    dbus_rdata    = '0;
    repeat (3) tick();
    nvec++;
    if (dbus_req !== 1'b0 || dbus_we !== 1'b0 || dbus_addr !== 32'd0 || dbus_be !== 4'd0 ||
        dbus_wdata !== 32'd0 || stallreq !== 1'b0) begin
      nerr++;
      $display("FAIL reset: req=%b we=%b addr=%h be=%b wdata=%h stall=%b, want all 0",
               dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, stallreq);
    end
    rst_ = 1'b1;
    tick();
  endtask

  task automatic test_passthrough;
    for (int i = 0; i < 10; i++) begin
      rand_ex();
      if (i == 0) begin
        ex_o_wdata = 32'h1234;
        ex_o_wreg  = 1'b1;
      end
      ex_o_mem_op   = MEM_NONE;
      ex_o_mem_addr = $urandom;
      #1;
      nvec++;
      if (mem_o_waddr !== ex_o_waddr || mem_o_wreg !== ex_o_wreg || mem_o_wdata !== ex_o_wdata ||
          mem_o_we_hilo !== ex_o_we_hilo || mem_o_wdata_hi !== ex_o_wdata_hi ||
          mem_o_wdata_lo !== ex_o_wdata_lo || stallreq !== 1'b0 || dbus_req !== 1'b0 ||
          mem_o_misalign !== 1'b0) begin
        nerr++;
        $display("FAIL pass %0d: wreg=%b wdata=%h stall=%b req=%b, want %b %h 0 0",
                 i, mem_o_wreg, mem_o_wdata, stallreq, dbus_req, ex_o_wreg, ex_o_wdata);
      end
      tick();
    end
  endtask

  task automatic test_directed;
    mem_txn(MEM_LB, 32'h101, 32'h11A23344, 0);
    mem_txn(MEM_LBU, 32'h101, 32'h11A23344, 0);
    rand_ex();
    ex_o_mem_sdata = 32'hDEADBEEF;
    ex_o_mem_op    = MEM_SH;
    ex_o_mem_addr  = 32'h202;
    ex_o_wreg      = 1'b0;
    #1;
    tick();
    nvec++;
    if (dbus_addr !== 32'h200 || dbus_be !== 4'b0011 || dbus_wdata !== 32'hBEEFBEEF || dbus_we !== 1'b1) begin
      nerr++;
      $display("FAIL sh_bus: addr=%h be=%b wdata=%h we=%b, want 00000200 0011 beefbeef 1",
               dbus_addr, dbus_be, dbus_wdata, dbus_we);
    end
    dbus_ack = 1'b1;
    tick();
    dbus_ack = 1'b0;
    #1;
    nvec++;
    if (mem_o_wreg !== 1'b0 || stallreq !== 1'b0) begin
      nerr++;
      $display("FAIL sh_done: wreg=%b stall=%b, want 0 0", mem_o_wreg, stallreq);
    end
    tick();
    ex_o_mem_op = MEM_NONE;
    #1;
  endtask

  task automatic test_misalign;
    for (int i = 0; i < 8; i++) begin
      rand_ex();
      ex_o_mem_op   = i == 0 ? MEM_LW : i == 1 ? MEM_LH : all_ops[2 + $urandom_range(0, 5)];
      ex_o_mem_addr = i == 0 ? 32'h3 : i == 1 ? 32'h5 : $urandom | 32'h1;
      if (i > 1 && ex_o_mem_op inside {MEM_LB, MEM_LBU, MEM_SB}) ex_o_mem_op = MEM_LW;
      #1;
      nvec++;
      if (mem_o_misalign !== 1'b1 || stallreq !== 1'b0 || mem_o_wreg !== 1'b0 || dbus_req !== 1'b0) begin
        nerr++;
        $display("FAIL misalign %s @%h: mis=%b stall=%b wreg=%b req=%b, want 1 0 0 0",
                 ex_o_mem_op.name(), ex_o_mem_addr, mem_o_misalign, stallreq, mem_o_wreg, dbus_req);
      end
      tick();
      ex_o_mem_op = MEM_NONE;
      #1;
      nvec++;
      if (mem_o_misalign !== 1'b0 || dbus_req !== 1'b0 || stallreq !== 1'b0) begin
        nerr++;
        $display("FAIL misalign_after: mis=%b req=%b stall=%b, want 0 0 0",
                 mem_o_misalign, dbus_req, stallreq);
      end
      tick();
    end
  endtask

  task automatic test_random;
    mem_op_e op;
    word_t   a;
    for (int i = 0; i < 40; i++) begin
      op = all_ops[$urandom_range(0, 7)];
      a  = $urandom;
      if (op inside {MEM_LH, MEM_LHU, MEM_SH}) a[0] = 1'b0;
      if (op inside {MEM_LW, MEM_SW}) a[1:0] = 2'b00;
      mem_txn(op, a, $urandom, $urandom_range(0, TO - 2));
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    rand_ex();
    ex_o_mem_op   = MEM_LW;
    ex_o_mem_addr = 32'h40;
    dbus_ack      = 1'b0;
    #1;
    tick();
    while (dbus_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    #1;
    nvec++;
    if (n != TO || mem_o_buserr !== 1'b1 || mem_o_wreg !== 1'b0 || stallreq !== 1'b0) begin
      nerr++;
      $display("FAIL timeout: req_cycles=%0d buserr=%b wreg=%b stall=%b, want %0d 1 0 0",
               n, mem_o_buserr, mem_o_wreg, stallreq, TO);
    end
    tick();
    ex_o_mem_op = MEM_NONE;
    dbus_ack    = 1'b1;
    dbus_rdata  = 32'hCAFEF00D;
    tick();
    dbus_ack = 1'b0;
    #1;
    nvec++;
    if (dbus_req !== 1'b0 || stallreq !== 1'b0 || mem_o_buserr !== 1'b0 || mem_o_wdata !== ex_o_wdata) begin
      nerr++;
      $display("FAIL late_ack: req=%b stall=%b buserr=%b wdata=%h, want 0 0 0 %h",
               dbus_req, stallreq, mem_o_buserr, mem_o_wdata, ex_o_wdata);
    end
  endtask

  task automatic test_reset_busy;
    rand_ex();
    ex_o_mem_op   = MEM_LW;
    ex_o_mem_addr = 32'h80;
    #1;
    tick();
    rst_ = 1'b0;
    tick();
    nvec++;
    if (dbus_req !== 1'b0) begin
      nerr++;
      $display("FAIL rst_busy: req=%b, want 0", dbus_req);
    end
    rst_        = 1'b1;
    ex_o_mem_op = MEM_NONE;
    dbus_ack    = 1'b1;
    dbus_rdata  = 32'h5A5A5A5A;
    tick();
    dbus_ack = 1'b0;
    #1;
    nvec++;
    if (dbus_req !== 1'b0 || stallreq !== 1'b0 || mem_o_wdata !== ex_o_wdata || mem_o_buserr !== 1'b0) begin
      nerr++;
      $display("FAIL rst_ack: req=%b stall=%b wdata=%h buserr=%b, want 0 0 %h 0",
               dbus_req, stallreq, mem_o_wdata, mem_o_buserr, ex_o_wdata);
    end
    mem_txn(MEM_LH, 32'h106, 32'h0000F00D, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_passthrough();
    test_directed();
    test_misalign();
    test_random();
    test_timeout();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
